// File: rtl/apb_rr_arbiter2_if.sv
// apb_rr_arbiter2_if: requester-side and APB-side signals of the shared APB master port
interface apb_rr_arbiter2_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req2, req_write2, done2;
  logic [NUM_REQ*ADDR_W-1:0] req_addr2;
  logic [NUM_REQ*DATA_W-1:0] req_wdata2;
  logic                      err2, busy2, pwrite2, psel2, penable2, pready2;
  logic [DATA_W-1:0]         rdata2, pwdata2, prdata2;
  logic [ADDR_W-1:0]         paddr2;
  modport master (
    input  req2, req_write2, req_addr2, req_wdata2, prdata2, pready2,
    output done2, err2, rdata2, busy2, paddr2, pwrite2, pwdata2, psel2, penable2
  );
  modport slave (
    output req2, req_write2, req_addr2, req_wdata2, prdata2, pready2,
    input  done2, err2, rdata2, busy2, paddr2, pwrite2, pwdata2, psel2, penable2
  );
endinterface

// File: rtl/apb_rr_arbiter2.sv
// apb_rr_arbiter2: round-robin arbiter running one APB SETUP/ACCESS transfer at a time,
// with wait-state support and a timeout that aborts transfers to a stuck slave.
module apb_rr_arbiter2 #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic               pclk2,
  input logic               n_preset2,
  apb_rr_arbiter2_if.master bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t              state_q, state_d;
  logic [GW-1:0]       last_q, last_d, win, idx;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                mask_q, found, err_q, err_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  elig;
  // The just-finished requester is masked for one cycle so a held req2 is not re-granted.
  always_comb begin
    elig = bus.req2;
    if (mask_q) elig[last_q] = 1'b0;
    found = 1'b0;
    win = last_q;
    idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = GW'((int'(last_q) + i) % NUM_REQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    case (state_q)
      IDLE: if (found) begin
        paddr_d  = bus.req_addr2[win*ADDR_W +: ADDR_W];
        pwdata_d = bus.req_wdata2[win*DATA_W +: DATA_W];
        pwrite_d = bus.req_write2[win];
        last_d   = win;
        state_d  = SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (bus.pready2) begin
        rdata_d = pwrite_q ? '0 : bus.prdata2;
        err_d   = 1'b0;
        state_d = DONE;
      end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT)) begin
        rdata_d = '0;
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge pclk2 or negedge n_preset2) begin
    if (!n_preset2) begin
      state_q  <= IDLE;
      last_q   <= GW'(NUM_REQ - 1);
      cnt_q    <= '0;
      mask_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      mask_q   <= state_q == DONE;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
    end
  end
  assign bus.psel2    = state_q == SETUP || state_q == ACCESS;
  assign bus.penable2 = state_q == ACCESS;
  assign bus.busy2    = state_q != IDLE;
  assign bus.done2    = state_q == DONE ? NUM_REQ'(1) << last_q : '0;
  assign bus.err2     = state_q == DONE && err_q;
  assign bus.rdata2   = state_q == DONE ? rdata_q : '0;
  assign bus.paddr2   = paddr_q;
  assign bus.pwdata2  = pwdata_q;
  assign bus.pwrite2  = pwrite_q;
endmodule

// File: tb/tb_apb_rr_arbiter2.sv
// tb_apb_rr_arbiter2: directed vectors for single transfers plus sequences for
// re-grant masking, reset during ACCESS and round-robin ordering.
module tb_apb_rr_arbiter2;
  localparam int N = 4, AW = 32, DW = 32;
  logic pclk2 = 1'b0, n_preset2 = 1'b0;
  int errors = 0, checks = 0;
  always #5 pclk2 = ~pclk2;
  apb_rr_arbiter2_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();
  apb_rr_arbiter2 #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .pclk2(pclk2), .n_preset2(n_preset2), .bus(bus)
  );
  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr, wdata, prd;
    int          waits;
    logic        drop, chg;
    logic [3:0]  e_done;
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_lat;
  } vec_t;
  vec_t vt[8];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Latency is counted in negedges after the request is raised; done at 3 + wait cycles.
  task automatic xfer(input vec_t v, input int k);
    int cyc = 0, ps = 0, pe = 0, bz = 0, bad_a = 0, bad_w = 0, bad_rw = 0;
    logic [3:0]  d = '0;
    logic [31:0] rd = '0;
    logic        er = 1'b0;
    repeat (2) @(negedge pclk2);
    bus.req2[v.id] = 1'b1;
    bus.req_write2[v.id] = v.wr;
    bus.req_addr2[v.id*AW +: AW] = v.addr;
    bus.req_wdata2[v.id*DW +: DW] = v.wdata;
    bus.prdata2 = v.prd;
    while (d == '0 && cyc < 40) begin
      @(negedge pclk2);
      cyc++;
      ps += int'(bus.psel2);
      pe += int'(bus.penable2);
      bz += int'(bus.busy2);
      if (bus.psel2) begin
        bad_a += int'(bus.paddr2 !== v.addr);
        bad_rw += int'(bus.pwrite2 !== v.wr);
        if (v.wr) bad_w += int'(bus.pwdata2 !== v.wdata);
        if (v.drop) bus.req2[v.id] = 1'b0;
        if (v.chg) bus.req_addr2[v.id*AW +: AW] = ~v.addr;
      end
      bus.pready2 = bus.penable2 ? (pe > v.waits) : 1'b1;
      d = bus.done2;
      rd = bus.rdata2;
      er = bus.err2;
    end
    bus.req2[v.id] = 1'b0;
    check($sformatf("v%0d done2", k), d, v.e_done);
    check($sformatf("v%0d rdata2", k), rd, v.e_rdata);
    check($sformatf("v%0d err2", k), er, v.e_err);
    check($sformatf("v%0d latency", k), cyc, v.e_lat);
    check($sformatf("v%0d psel cycles", k), ps, v.e_lat - 1);
    check($sformatf("v%0d penable cycles", k), pe, v.e_lat - 2);
    check($sformatf("v%0d busy cycles", k), bz, v.e_lat);
    check($sformatf("v%0d paddr unstable", k), bad_a, 0);
    check($sformatf("v%0d pwrite wrong", k), bad_rw, 0);
    check($sformatf("v%0d pwdata wrong", k), bad_w, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] exp_ord[5];
    int         n_done, tmo;
    logic [3:0] seen[8];
    int         when[8];
    vt[0] = '{2, 1'b0, 32'h00A1_0004, 32'h0,         32'hDEAD_BEEF, 0,  1'b0, 1'b0, 4'b0100, 32'hDEAD_BEEF, 1'b0, 3};
    vt[1] = '{0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'hAAAA_5555, 3,  1'b0, 1'b0, 4'b0001, 32'h0,         1'b0, 6};
    vt[2] = '{3, 1'b0, 32'h8000_00FC, 32'h0,         32'h0BAD_F00D, 2,  1'b1, 1'b0, 4'b1000, 32'h0BAD_F00D, 1'b0, 5};
    vt[3] = '{1, 1'b0, 32'h0000_0400, 32'h0,         32'hCAFE_0001, 0,  1'b0, 1'b1, 4'b0010, 32'hCAFE_0001, 1'b0, 3};
    vt[4] = '{0, 1'b0, 32'h0000_0020, 32'h0,         32'h5A5A_A5A5, 8,  1'b0, 1'b0, 4'b0001, 32'h5A5A_A5A5, 1'b0, 11};
    vt[5] = '{2, 1'b0, 32'h0000_0030, 32'h0,         32'h7777_7777, 99, 1'b0, 1'b0, 4'b0100, 32'h0,         1'b1, 11};
    vt[6] = '{3, 1'b1, 32'h0000_0040, 32'hFEED_FACE, 32'h3333_3333, 0,  1'b0, 1'b0, 4'b1000, 32'h0,         1'b0, 3};
    vt[7] = '{1, 1'b0, 32'h0000_0050, 32'h0,         32'h0102_0304, 7,  1'b0, 1'b0, 4'b0010, 32'h0102_0304, 1'b0, 10};
    exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req2 = '0;
    bus.req_write2 = '0;
    bus.req_addr2 = '0;
    bus.req_wdata2 = '0;
    bus.prdata2 = '0;
    bus.pready2 = 1'b0;
    repeat (3) @(negedge pclk2);
    check("reset psel2", bus.psel2, 0);
    check("reset penable2", bus.penable2, 0);
    check("reset done2", bus.done2, 0);
    check("reset busy2", bus.busy2, 0);
    check("reset err2", bus.err2, 0);
    check("reset rdata2", bus.rdata2, 0);
    check("reset paddr2", bus.paddr2, 0);
    check("reset pwdata2", bus.pwdata2, 0);
    check("reset pwrite2", bus.pwrite2, 0);
    n_preset2 = 1'b1;
    for (int k = 0; k < 8; k++) xfer(vt[k], k);
    // Requester 1 keeps req2 high after done2: no grant in the following IDLE cycle.
    repeat (2) @(negedge pclk2);
    bus.req2[1] = 1'b1;
    bus.req_write2[1] = 1'b0;
    bus.req_addr2[1*AW +: AW] = 32'h0000_0444;
    bus.prdata2 = 32'h1111_2222;
    bus.pready2 = 1'b1;
    tmo = 0;
    while (bus.done2 == '0 && tmo < 20) begin
      @(negedge pclk2);
      tmo++;
      if (bus.psel2) begin
        check("mask paddr2 held", bus.paddr2, 32'h0000_0444);
        bus.req_addr2[1*AW +: AW] = 32'h0000_0888;
      end
    end
    check("mask first done2", bus.done2, 4'b0010);
    @(negedge pclk2);
    @(negedge pclk2);
    check("mask no regrant psel2", bus.psel2, 0);
    @(negedge pclk2);
    check("mask later regrant psel2", bus.psel2, 1);
    check("mask regrant paddr2", bus.paddr2, 32'h0000_0888);
    bus.req2[1] = 1'b0;
    repeat (4) @(negedge pclk2);
    // Reset while requester 2 sits in ACCESS with a slave that never answers.
    bus.req2[2] = 1'b1;
    bus.pready2 = 1'b0;
    tmo = 0;
    while (!bus.penable2 && tmo < 10) begin
      @(negedge pclk2);
      tmo++;
    end
    check("pre-reset penable2", bus.penable2, 1);
    #2 n_preset2 = 1'b0;
    #1;
    check("async reset psel2", bus.psel2, 0);
    check("async reset penable2", bus.penable2, 0);
    bus.req2 = 4'hF;
    bus.pready2 = 1'b1;
    n_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk2);
      n_done += int'(bus.done2 != '0);
    end
    check("no done2 in reset", n_done, 0);
    n_preset2 = 1'b1;
    n_done = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge pclk2);
      if (bus.done2 != '0 && n_done < 8) begin
        seen[n_done] = bus.done2;
        when[n_done] = c;
        n_done++;
      end
    end
    bus.req2 = '0;
    check("rr done count", n_done, 5);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("rr order %0d", j), j < n_done ? seen[j] : 4'h0, exp_ord[j]);
      check($sformatf("rr cycle %0d", j), j < n_done ? when[j] : -1, 3 + 4 * j);
    end
    repeat (2) @(negedge pclk2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
